mult_reduce_p1305: RTL

MULT_REDUCE_P1305 -- requirements
Module: mult_reduce_p1305

---
 rtl/mult_reduce_p1305.sv | 117 +++++++++++
 1 files changed

// File: rtl/mult_reduce_p1305.sv
// rtl/mult_reduce_p1305.sv - three-step reduction of a 258-bit product modulo 2^130-5
//
// Purpose:
//   Reduces the unreduced 258-bit product of a 130x128 multiply to its
//   canonical residue modulo p = 2^130 - 5. It uses the identity
//   2^130 == 5 (mod p): two folds, then one conditional subtract.
//   There is no multiplier; 5*x is formed as (x << 2) + x.
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   reset_n    - asynchronous active-low reset
//   start      - request, accepted only while busy is low
//   prod_in    - 258-bit unreduced product, captured on the accepting edge
//   result_out - 130-bit canonical residue, registered, held between results
//   busy       - high from the cycle after acceptance until the done cycle
//   done       - one-cycle pulse marking result_out valid
//
// Timing:
//   accept at edge T, fold 1 at T+1, fold 2 at T+2, final subtract and
//   done at T+3. A start seen during the done cycle is accepted, which
//   gives one result every 4 cycles.

module mult_reduce_p1305 (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [257:0] prod_in,
  output logic [129:0] result_out,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FOLD1 = 2'd1,
    FOLD2 = 2'd2,
    FINAL = 2'd3
  } state_t;

  // p = 2^130 - 5, held one bit wider so the compare with h2 needs no extension.
  localparam logic [130:0] P_MOD = (131'd1 << 130) - 131'd5;

  state_t       state;
  logic [257:0] p_reg;
  logic [131:0] h1;
  logic [130:0] h2;

  // Fold 1: P[257:130] is 128 bits, so 5*P_hi < 2^131 and h1 < 2^132.
  logic [131:0] p_hi_ext;
  logic [131:0] p_hi_x5;
  logic [131:0] h1_next;

  assign p_hi_ext = {4'b0, p_reg[257:130]};
  assign p_hi_x5  = (p_hi_ext << 2) + p_hi_ext;
  assign h1_next  = {2'b0, p_reg[129:0]} + p_hi_x5;

  // Fold 2: h1[131:130] is at most 3, so the term added is at most 15.
  logic [130:0] h1_hi_ext;
  logic [130:0] h1_hi_x5;
  logic [130:0] h2_next;

  assign h1_hi_ext = {129'b0, h1[131:130]};
  assign h1_hi_x5  = (h1_hi_ext << 2) + h1_hi_ext;
  assign h2_next   = {1'b0, h1[129:0]} + h1_hi_x5;

  // h2 < 2^130 + 15 < 2p, so one conditional subtract gives the canonical residue.
  logic         h2_ge_p;
  logic [130:0] h2_minus_p;
  logic [129:0] result_next;

  assign h2_ge_p     = (h2 >= P_MOD);
  assign h2_minus_p  = h2 - P_MOD;
  assign result_next = h2_ge_p ? h2_minus_p[129:0] : h2[129:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      p_reg      <= '0;
      h1         <= '0;
      h2         <= '0;
      result_out <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // done is a pulse: it is set only in the FINAL branch.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            p_reg <= prod_in;
            busy  <= 1'b1;
            state <= FOLD1;
          end
        end
        FOLD1: begin
          h1    <= h1_next;
          state <= FOLD2;
        end
        FOLD2: begin
          h2    <= h2_next;
          state <= FINAL;
        end
        FINAL: begin
          result_out <= result_next;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
